// File: rtl/eic_cpu_responder.sv
// eic_cpu_responder: processor-side EIC endpoint. Accepts controller
// requests above cur_ipl, acks, clears the EIFRC flag, dispatches a handler.
// Ports: CLK/RESETn; EIC_* request inputs; int_enable, eret, handler_ready
// from the core; cur_ipl, irq_ack, write_*, handler_*, nest_depth,
// eret_err, busy outputs.
module eic_cpu_responder #(
  parameter int          ADDR_WIDTH    = 5,
  parameter logic [4:0]  EIFRC0_ADDR   = 5'h06,
  parameter logic [4:0]  EIFRC1_ADDR   = 5'h07,
  parameter int          STACK_DEPTH   = 4,
  parameter logic [31:0] VEC_BASE      = 32'h8000_0200,
  parameter int          SPACING_SHIFT = 5
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  EIC_Present,
  input  logic [7:0]            EIC_Interrupt,
  input  logic [5:0]            EIC_Vector,
  input  logic [16:0]           EIC_Offset,
  input  logic                  int_enable,
  input  logic                  eret,
  input  logic                  handler_ready,
  output logic [7:0]            cur_ipl,
  output logic                  irq_ack,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]           write_data,
  output logic                  write_enable,
  output logic [31:0]           handler_addr,
  output logic                  handler_valid,
  output logic [3:0]            nest_depth,
  output logic                  eret_err,
  output logic                  busy
);

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE, ACCEPT, CLEAR, DISPATCH
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rq_ripl_q, rq_ripl_d;
  logic [5:0]  rq_vec_q, rq_vec_d;
  logic [16:0] rq_off_q, rq_off_d;
  logic [7:0]  ripl_q, ripl_d;
  logic [5:0]  vec_q, vec_d;
  logic [16:0] off_q, off_d;
  logic [7:0]  cur_q, cur_d;
  logic [3:0]  dep_q, dep_d;
  logic        err_q, err_d;
  logic [7:0]  stk_q [STACK_DEPTH];
  logic [7:0]  stk_d [STACK_DEPTH];

  logic          acc;
  logic [IW-1:0] push_idx, pop_idx;
  logic [7:0]    n;

  assign push_idx = IW'(dep_q);
  assign pop_idx  = IW'(dep_q - 4'd1);

  always_comb begin
    rq_ripl_d = EIC_Interrupt;
    rq_vec_d  = EIC_Vector;
    rq_off_d  = EIC_Offset;
    state_d   = state_q;
    ripl_d    = ripl_q;
    vec_d     = vec_q;
    off_d     = off_q;
    cur_d     = cur_q;
    dep_d     = dep_q;
    err_d     = 1'b0;
    stk_d     = stk_q;
    acc = EIC_Present & int_enable
        & (rq_ripl_q > cur_q)
        & (dep_q < 4'(STACK_DEPTH))
        & ~eret;
    unique case (state_q)
      IDLE: begin
        // ERET beats a simultaneous accept
        if (eret) begin
          if (dep_q != 4'd0) begin
            cur_d = stk_q[pop_idx];
            dep_d = dep_q - 4'd1;
          end else begin
            cur_d = 8'd0;
            err_d = 1'b1;
          end
        end else if (acc) begin
          stk_d[push_idx] = cur_q;
          dep_d   = dep_q + 4'd1;
          cur_d   = rq_ripl_q;
          ripl_d  = rq_ripl_q;
          vec_d   = rq_vec_q;
          off_d   = rq_off_q;
          state_d = ACCEPT;
        end
      end
      ACCEPT:   state_d = CLEAR;
      CLEAR:    state_d = DISPATCH;
      DISPATCH: if (handler_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= IDLE;
      rq_ripl_q <= '0;
      rq_vec_q  <= '0;
      rq_off_q  <= '0;
      ripl_q    <= '0;
      vec_q     <= '0;
      off_q     <= '0;
      cur_q     <= '0;
      dep_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rq_ripl_q <= rq_ripl_d;
      rq_vec_q  <= rq_vec_d;
      rq_off_q  <= rq_off_d;
      ripl_q    <= ripl_d;
      vec_q     <= vec_d;
      off_q     <= off_d;
      cur_q     <= cur_d;
      dep_q     <= dep_d;
      err_q     <= err_d;
      stk_q     <= stk_d;
    end
  end

  // flag index n = ripl-1 selects word and bit of EIFRC
  assign n = ripl_q - 8'd1;

  always_comb begin
    write_addr   = '0;
    write_data   = '0;
    handler_addr = '0;
    write_enable = (state_q == CLEAR);
    handler_valid = (state_q == DISPATCH);
    if (write_enable) begin
      write_addr = (n < 8'd32) ? ADDR_WIDTH'(EIFRC0_ADDR)
                               : ADDR_WIDTH'(EIFRC1_ADDR);
      write_data = 32'd1 << n[4:0];
    end
    if (handler_valid) begin
      if (off_q != 17'd0)
        handler_addr = VEC_BASE + {14'd0, off_q, 1'b0};
      else
        handler_addr = VEC_BASE + (32'(vec_q) << SPACING_SHIFT);
    end
  end

  assign irq_ack    = (state_q == ACCEPT);
  assign cur_ipl    = cur_q;
  assign nest_depth = dep_q;
  assign eret_err   = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_eic_cpu_responder.sv
// tb_eic_cpu_responder: directed bench for eic_cpu_responder.
// Drives request vectors and checks outputs against hand-computed values.
module tb_eic_cpu_responder;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        EIC_Present = 1'b0;
  logic [7:0]  EIC_Interrupt = '0;
  logic [5:0]  EIC_Vector = '0;
  logic [16:0] EIC_Offset = '0;
  logic        int_enable = 1'b0;
  logic        eret = 1'b0;
  logic        handler_ready = 1'b1;
  logic [7:0]  cur_ipl;
  logic        irq_ack;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] handler_addr;
  logic        handler_valid;
  logic [3:0]  nest_depth;
  logic        eret_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  eic_cpu_responder dut (
    .CLK(CLK), .RESETn(RESETn),
    .EIC_Present(EIC_Present), .EIC_Interrupt(EIC_Interrupt),
    .EIC_Vector(EIC_Vector), .EIC_Offset(EIC_Offset),
    .int_enable(int_enable), .eret(eret),
    .handler_ready(handler_ready), .cur_ipl(cur_ipl),
    .irq_ack(irq_ack), .write_addr(write_addr),
    .write_data(write_data), .write_enable(write_enable),
    .handler_addr(handler_addr), .handler_valid(handler_valid),
    .nest_depth(nest_depth), .eret_err(eret_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 10 && !irq_ack; i++) step();
    chk(tag, {31'd0, irq_ack}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) step();
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic req(input logic [7:0] r, input string tag);
    EIC_Interrupt = r;
    wait_ack(tag);
    EIC_Interrupt = '0;
    wait_idle({tag, "_idle"});
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  task automatic no_accept(input string tag);
    int hits;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (irq_ack || write_enable) hits++;
    end
    chk(tag, hits, 0);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_cur", cur_ipl, 0);
    chk("rst_out", {irq_ack, write_enable, handler_valid, eret_err, busy}, 0);
    chk("rst_dep", nest_depth, 0);
    RESETn = 1'b1;
    step();
    EIC_Present = 1'b1;
    int_enable = 1'b1;

    // basic: ripl 5, vector 5, two-cycle latency
    EIC_Interrupt = 8'd5;
    EIC_Vector = 6'd5;
    step();
    chk("lat1_ack", irq_ack, 0);
    step();
    chk("lat2_ack", irq_ack, 1);
    chk("b_cur", cur_ipl, 5);
    EIC_Interrupt = '0;
    step();
    chk("b_we", write_enable, 1);
    chk("b_wa", write_addr, 5'h06);
    chk("b_wd", write_data, 32'h10);
    step();
    chk("b_we_off", {write_enable, write_addr, write_data}, 0);
    chk("b_hv", handler_valid, 1);
    chk("b_ha", handler_addr, 32'h8000_02A0);
    chk("b_dep", nest_depth, 1);
    step();
    chk("b_done", {handler_valid, busy}, 0);
    do_eret();
    chk("b_pop", {nest_depth, cur_ipl}, 0);

    // ripl 40 -> word1, handler held
    handler_ready = 1'b0;
    EIC_Interrupt = 8'd40;
    EIC_Vector = 6'd2;
    wait_ack("w1_ack");
    EIC_Interrupt = '0;
    step();
    chk("w1_wa", write_addr, 5'h07);
    chk("w1_wd", write_data, 32'h80);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("w1_hv", handler_valid, 1);
      chk("w1_ha", handler_addr, 32'h8000_0240);
      if (i == 3) handler_ready = 1'b1;
    end
    step();
    chk("w1_rel", handler_valid, 0);
    do_eret();

    // nesting
    req(8'd3, "n3");
    req(8'd7, "n7");
    chk("n_dep", nest_depth, 2);
    chk("n_cur", cur_ipl, 7);
    do_eret();
    chk("n_e1", {nest_depth, cur_ipl}, {4'd1, 8'd3});
    do_eret();
    chk("n_e2", {nest_depth, cur_ipl}, 0);
    do_eret();
    chk("n_err", eret_err, 1);
    chk("n_e3cur", cur_ipl, 0);
    step();
    chk("n_errclr", eret_err, 0);

    // blocking
    req(8'd7, "bk7");
    EIC_Interrupt = 8'd4;
    no_accept("bk_low");
    EIC_Interrupt = 8'd9;
    int_enable = 1'b0;
    no_accept("bk_ie");
    int_enable = 1'b1;
    EIC_Present = 1'b0;
    no_accept("bk_pres");
    EIC_Present = 1'b1;
    EIC_Interrupt = '0;
    do_eret();
    req(8'd1, "f1");
    req(8'd2, "f2");
    req(8'd3, "f3");
    req(8'd4, "f4");
    EIC_Interrupt = 8'd9;
    no_accept("bk_full");
    chk("full_dep", nest_depth, 4);
    EIC_Interrupt = '0;
    for (int i = 0; i < 4; i++) do_eret();
    chk("full_pop", {nest_depth, cur_ipl}, 0);

    // ERET beats simultaneous accept
    req(8'd2, "e2");
    EIC_Interrupt = 8'd9;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("ea_noack", irq_ack, 0);
    chk("ea_pop", {nest_depth, cur_ipl}, 0);
    step();
    chk("ea_ack", irq_ack, 1);
    chk("ea_cur", {nest_depth, cur_ipl}, {4'd1, 8'd9});
    EIC_Interrupt = '0;
    wait_idle("ea_idle");
    do_eret();

    // offset path, reset during DISPATCH
    handler_ready = 1'b0;
    EIC_Offset = 17'h100;
    EIC_Vector = 6'd3;
    EIC_Interrupt = 8'd6;
    wait_ack("of_ack");
    EIC_Interrupt = '0;
    step();
    step();
    chk("of_ha", handler_addr, 32'h8000_0400);
    RESETn = 1'b0;
    #1;
    chk("of_rst", {handler_valid, write_enable, irq_ack, busy}, 0);
    chk("of_rst_ha", handler_addr, 0);
    chk("of_rst_st", {nest_depth, cur_ipl}, 0);
    step();
    RESETn = 1'b1;
    begin
      int wes;
      wes = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        if (write_enable) wes++;
      end
      chk("of_nowe", wes, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eic_cpu_responder.md
Name: eic_cpu_responder

Overview:
Processor-side endpoint of the EIC interrupt interface. It consumes the controller's EIC_Interrupt/EIC_Vector/EIC_Offset/EIC_Present outputs and accepts a request when its level beats the current priority level. On acceptance it acknowledges, then clears the serviced flag by writing the controller's EIFRC register. It then dispatches a handler address to the core, and keeps a nesting stack of priority levels restored on ERET.

Parameters:
ADDR_WIDTH, 5, width of write_addr; must match the controller register address width
EIFRC0_ADDR, 5'h06, register address of EIFRC word0, which holds flags 0..31
EIFRC1_ADDR, 5'h07, register address of EIFRC word1, which holds flags 32..63
STACK_DEPTH, 4, maximum nesting depth (1..8)
VEC_BASE, 32'h8000_0200, handler table base address
SPACING_SHIFT, 5, vector spacing = 2^SPACING_SHIFT bytes

Ports:
CLK  in  1  clock
RESETn  in  1  asynchronous active-low reset
EIC_Present  in  1  controller enabled
EIC_Interrupt  in  8  requested level (RIPL); 0 means no request
EIC_Vector  in  6  requested vector
EIC_Offset  in  17  explicit handler offset [17:1]; 0 means use vector
int_enable  in  1  core global interrupt enable
eret  in  1  one-cycle pulse: handler return
handler_ready  in  1  core consumes handler_addr
cur_ipl  out  8  current interrupt priority level
irq_ack  out  1  one-cycle acknowledge pulse
write_addr  out  ADDR_WIDTH  EIFRC register address
write_data  out  32  clear mask
write_enable  out  1  one-cycle register write strobe
handler_addr  out  32  handler entry address
handler_valid  out  1  handler_addr valid
nest_depth  out  4  stack occupancy
eret_err  out  1  one-cycle pulse on underflow ERET
busy  out  1  state != IDLE

Behaviour:
- Reset (async, RESETn=0): state IDLE; all outputs 0; stack empty; cur_ipl=0. Reset mid-operation aborts any pending write or dispatch; no write_enable is issued after reset release until a new accept.
- Inputs are registered once (req_q); all decisions use req_q, so minimum latency from request to irq_ack is 2 cycles.
- Accept condition, evaluated in IDLE only: EIC_Present & int_enable & req_q.ripl > cur_ipl & nest_depth < STACK_DEPTH & ~eret.
- FSM:
  - IDLE -> ACCEPT on the accept condition.
  - ACCEPT (1 cycle): push cur_ipl; cur_ipl <= ripl; latch ripl, vector and offset; irq_ack=1. Next: CLEAR.
  - CLEAR (1 cycle): write_enable=1. Let n = ripl-1. write_addr = EIFRC0_ADDR if n<32, else EIFRC1_ADDR. write_data = 1<<(n[4:0]). Next: DISPATCH.
  - DISPATCH: handler_valid=1. handler_addr = VEC_BASE + {offset,1'b0} if offset != 0, else VEC_BASE + (vector<<SPACING_SHIFT), as a 32-bit wraparound add. handler_addr is held stable until handler_ready; on handler_valid & handler_ready go to IDLE.
- write_addr/write_data are 0 whenever write_enable=0.
- ERET, honoured in IDLE only:
  - If the stack is non-empty: pop; cur_ipl <= popped value; nest_depth-1.
  - If the stack is empty: cur_ipl <= 0 and eret_err pulses 1 cycle.
  - ERET in any non-IDLE state is ignored; no latching.
- Simultaneous ERET and accept condition in IDLE: ERET wins; the accept is re-evaluated the next cycle against the restored cur_ipl.
- A request whose level changes or disappears after ACCEPT does not alter the transaction.
- A higher request arriving in CLEAR or DISPATCH is taken only on return to IDLE.
- Stack full (nest_depth=STACK_DEPTH): no accept regardless of level.
- ripl=0 never satisfies accept, since cur_ipl >= 0.

Test Plan:
- Reset, then RIPL=5, vector=5, offset=0, int_enable=1 -> irq_ack 2 cycles later; cur_ipl=5; write_enable 1 cycle with addr=EIFRC0_ADDR, data=32'h10; handler_addr=0x8000_02A0; nest_depth=1.
- RIPL=40 -> write_addr=EIFRC1_ADDR, data=32'h80. With handler_ready held low 3 cycles, handler_addr stays stable and handler_valid=1 for 4 cycles.
- Nesting: accept RIPL=3, then RIPL=7 -> nest_depth=2, cur_ipl=7. ERET -> cur_ipl=3; ERET -> 0; third ERET -> eret_err pulse, cur_ipl=0.
- Blocking: cur_ipl=7 with RIPL=4, or int_enable=0, or EIC_Present=0, or stack full -> no irq_ack and no write_enable for 20 cycles.
- ERET and a qualifying RIPL=9 in the same IDLE cycle -> pop happens first; accept follows one cycle later.
- Offset=17'h100 -> handler_addr=0x8000_0400. Assert RESETn low during DISPATCH -> all outputs 0 immediately; no write_enable after release.
